// File: rtl/instr_encoder.sv
// instr_encoder: loads a session of instruction requests into instruction
// memory, encoding each request into a 32-bit MIPS-style word.
//
// The encoder handles one word every two cycles:
//   1. It accepts a request in ACCEPT.
//   2. It strobes the write in WRITE.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start, base_addr session start (sampled in IDLE only), first word address
//   in_valid/ready   request handshake (ready only in ACCEPT)
//   in_op..in_last   request fields; in_last ends the session
//   imem_we/addr/wdata  instruction-memory write port
//   busy, done, err  status: not-idle, one-cycle completion, illegal op seen
//   count            words written this session
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] count
);

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERR} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_word;
  logic        r_last, r_err;
  logic [15:0] r_count;
  logic [31:0] w_word;
  logic        w_illegal;

  // Combinational encoder. Fields not used by an op are ignored.
  always_comb begin
    w_word    = 32'h0;
    w_illegal = 1'b0;
    case (in_op)
      4'd0:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
      4'd1:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
      4'd2:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100100};
      4'd3:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100101};
      4'd4:  w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
      4'd5:  w_word = {6'b001000, in_rs, in_rt, in_imm};
      4'd6:  w_word = {6'b001010, in_rs, in_rt, in_imm};
      4'd7:  w_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd8:  w_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd9:  w_word = {6'b000010, in_target};
      4'd10: w_word = {6'b000011, in_target};
      4'd11: w_word = {6'b000111, in_rs, 21'b0};
      4'd12: w_word = {6'b000100, in_rs, in_rt, in_imm};
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ACCEPT;
      S_ACCEPT: if (in_valid) w_next = w_illegal ? S_ERR : S_WRITE;
      S_WRITE:  w_next = r_last ? S_DONE : S_ACCEPT;
      S_DONE:   w_next = S_IDLE;
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 32'h0;
      r_word  <= 32'h0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= 16'h0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_addr  <= base_addr;
          r_count <= 16'h0;
          r_err   <= 1'b0;
        end
        S_ACCEPT: if (in_valid) begin
          if (w_illegal) r_err <= 1'b1;
          else begin
            r_word <= w_word;
            r_last <= in_last;
          end
        end
        // Both counters wrap naturally at their widths.
        S_WRITE: begin
          r_addr  <= r_addr + 32'd4;
          r_count <= r_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Decoding the strobes from the state register lets reset drop them
  // in the same cycle.
  assign in_ready   = (r_state == S_ACCEPT);
  assign imem_we    = (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign err        = r_err;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_word;
  assign count      = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  logic        clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0;
  logic [31:0] base_addr = 0;
  logic [3:0]  in_op = 0;
  logic [4:0]  in_rs = 0, in_rt = 0, in_rd = 0;
  logic [15:0] in_imm = 0;
  logic [25:0] in_target = 0;
  logic        in_ready, imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] count;
  int checks = 0, failures = 0;

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] base);
    @(negedge clk); start = 1; base_addr = base;
    @(negedge clk); start = 0; base_addr = 32'hDEAD_BEEF;
  endtask

  // Present one request in ACCEPT; return at the negedge of the write cycle.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                      input logic [31:0] exp_w, input logic [31:0] exp_a);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 10) begin @(negedge clk); n++; end
    chk("ready", in_ready, 1);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_target = tgt; in_last = last; in_valid = 1;
    @(negedge clk); in_valid = 0; in_last = 0;
    chk("we", imem_we, 1);
    chk("addr", imem_addr, exp_a);
    chk("wdata", imem_wdata, exp_w);
    chk("ready_in_write", in_ready, 0);
  endtask

  task automatic finish_session(input logic [15:0] exp_cnt);
    @(negedge clk);
    chk("done", done, 1);
    chk("we_after", imem_we, 0);
    chk("count", count, exp_cnt);
    @(negedge clk);
    chk("done_1cyc", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_we", imem_we, 0); chk("rst_busy", busy, 0); chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_count", count, 0);
    chk("rst_addr", imem_addr, 0); chk("rst_wdata", imem_wdata, 0);
    rst = 0;
    // in_valid in IDLE is ignored
    @(negedge clk); in_valid = 1; in_op = 5;
    @(negedge clk); chk("idle_valid_we", imem_we, 0); chk("idle_valid_busy", busy, 0);
    in_valid = 0;

    // Encode check
    do_start(32'h100);
    chk("busy_accept", busy, 1);
    send(4'd5, 5'd1, 5'd2, 5'd9, 16'h0005, 26'h3FF_FFFF, 1, 32'h2022_0005, 32'h100);
    finish_session(16'd1);

    // Sequence check, with a start pulse during ACCEPT that must be ignored
    do_start(32'h0);
    @(negedge clk); start = 1; base_addr = 32'h5000;
    @(negedge clk); start = 0;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h0, 0, 32'h0022_1820, 32'h0);
    send(4'd12, 5'd3, 5'd0, 5'd7, 16'hFFFF, 26'h0, 0, 32'h1060_FFFF, 32'h4);
    send(4'd9, 5'd4, 5'd5, 5'd6, 16'h1234, 26'h000_0040, 1, 32'h0800_0040, 32'h8);
    finish_session(16'd3);

    // Jump encodings plus remaining R/I types
    do_start(32'h1000);
    send(4'd11, 5'd31, 5'd7, 5'd7, 16'hABCD, 26'h155_5555, 0, 32'h1FE0_0000, 32'h1000);
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 0, 32'h0085_3022, 32'h1004);
    send(4'd4, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 0, 32'h0021_082A, 32'h1008);
    send(4'd8, 5'd29, 5'd31, 5'd0, 16'h8000, 26'h0, 0, 32'hAFBF_8000, 32'h100C);
    send(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1, 32'h0FFF_FFFF, 32'h1010);
    finish_session(16'd5);

    // Illegal op
    do_start(32'h300);
    @(negedge clk); in_op = 4'd14; in_valid = 1;
    @(negedge clk); in_valid = 0;
    chk("err_state_we", imem_we, 0); chk("err_flag", err, 1); chk("err_busy", busy, 1);
    @(negedge clk);
    chk("err_idle_busy", busy, 0); chk("err_held", err, 1); chk("err_no_done", done, 0);
    do_start(32'h300);
    chk("err_cleared", err, 0); chk("count_cleared", count, 0);
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1, 32'h0022_1824, 32'h300);
    finish_session(16'd1);

    // Address wrap
    do_start(32'hFFFF_FFFC);
    send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 0, 32'h0022_1825, 32'hFFFF_FFFC);
    send(4'd7, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 1, 32'h8C43_0010, 32'h0000_0000);
    finish_session(16'd2);

    // Reset during WRITE
    do_start(32'h40);
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'h7FFF, 26'h0, 0, 32'h2822_7FFF, 32'h40);
    rst = 1; #1;
    chk("rstw_we", imem_we, 0); chk("rstw_busy", busy, 0); chk("rstw_count", count, 0);
    chk("rstw_addr", imem_addr, 0); chk("rstw_wdata", imem_wdata, 0);
    chk("rstw_ready", in_ready, 0); chk("rstw_err", err, 0);
    @(negedge clk); rst = 0;
    @(negedge clk); chk("rstw_idle", busy, 0);
    do_start(32'h200);
    send(4'd5, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0, 1, 32'h2022_0005, 32'h200);
    finish_session(16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL expose these ports: clk  in  1  single rising-edge clock.
REQ-002 rst  in  1  asynchronous active-high reset.
REQ-003 start  in  1  begins a load session; ignored unless state is IDLE.
REQ-004 base_addr  in  32  byte address of the first instruction word; sampled on start.
REQ-005 in_valid  in  1  instruction request present.
REQ-006 in_ready  out  1  encoder accepts a request this cycle.
REQ-007 in_op  in  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 slti, 7 lw, 8 sw, 9 j, 10 jal, 11 jr, 12 beq; 13-15 illegal.
REQ-008 in_rs, in_rt, in_rd  in  5 each  register fields.
REQ-009 in_imm  in  16  immediate or branch offset.
REQ-010 in_target  in  26  jump target field.
REQ-011 in_last  in  1  marks the final request of the session.
REQ-012 imem_we  out  1  instruction-memory write strobe.
REQ-013 imem_addr  out  32  write byte address.
REQ-014 imem_wdata  out  32  encoded instruction word.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle session-complete pulse.
REQ-017 err  out  1  illegal op seen; held until the next accepted start.
REQ-018 count  out  16  number of words written this session.

Function
REQ-019 The FSM SHALL have the states IDLE, ACCEPT, WRITE, DONE and ERR, all registered.
REQ-020 IDLE: on start, load addr_reg=base_addr, clear count and err, and go to ACCEPT.
REQ-021 ACCEPT: in_ready=1; on in_valid, register the encoded word and in_last, and go to WRITE; for an illegal in_op, go to ERR and write nothing.
REQ-022 WRITE: imem_we=1 for exactly one cycle with imem_addr=addr_reg and imem_wdata=the registered word.
REQ-023 On leaving WRITE, addr_reg+=4 and count+=1; go to DONE if last was registered, else to ACCEPT.
REQ-024 DONE: done=1 for one cycle, then go to IDLE.
REQ-025 ERR: err=1 and busy=1, then go to IDLE on the next cycle; err stays high in IDLE until start.
REQ-026 in_ready SHALL be 0 in every state except ACCEPT.
REQ-027 Throughput SHALL be one word per 2 cycles: accept at edge N, write strobe during cycle N+1.
REQ-028 R-type words (ops 0-4) SHALL be {6'b000000, rs, rt, rd, 5'b0, funct}.
REQ-029 R-type funct SHALL be add 100000, sub 100010, and 100100, or 100101, slt 101010.
REQ-030 I-type words SHALL be {opc, rs, rt, imm} with opc addi 001000, slti 001010, lw 100011, sw 101011, beq 000100.
REQ-031 j SHALL encode {000010, target}; jal SHALL encode {000011, target}.
REQ-032 jr SHALL encode {000111, rs, 21'b0}.
REQ-033 Unused fields SHALL be taken only from the positions specified above; other inputs are don't-care.
REQ-034 addr_reg SHALL wrap modulo 2^32, and count SHALL wrap modulo 2^16.
REQ-035 start while busy SHALL be ignored with no state change.
REQ-036 in_valid outside ACCEPT SHALL be ignored; the request is not consumed.

Reset
REQ-037 rst SHALL asynchronously force IDLE, and imem_we, in_ready, busy, done and err to 0.
REQ-038 rst SHALL asynchronously force count=0, addr_reg=0 and imem_addr=0, imem_wdata=0.
REQ-039 rst asserted mid-WRITE SHALL drop imem_we immediately, with no partial increment.
REQ-040 After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-041 Encode check: start with base 0x100, send addi rs=1 rt=2 imm=0x0005 with last -> one write of 0x20220005 at 0x100, then a done pulse and count=1.
REQ-042 Sequence check: send add(1,2,3), beq(3,0,0xFFFF), j(0x0000040), last on j -> writes 0x00221820 at 0x0, 0x1060FFFF at 0x4, 0x08000040 at 0x8, count=3.
REQ-043 Jump encodings: jr rs=31 -> 0x1FE00000; jal target 0x3FFFFFF -> 0x0FFFFFFF.
REQ-044 Illegal op: in_op=14 -> no imem_we, err=1, return to IDLE; the next start clears err.
REQ-045 Wrap: base 0xFFFFFFFC with two words -> writes at 0xFFFFFFFC then 0x00000000.
REQ-046 Reset mid-session: assert rst during WRITE -> imem_we=0 the same cycle and all outputs at reset values; a later start restarts at the new base_addr.
